// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline MEM stage: widths, FSM
// encoding, the word-alignment mask and the bubble control value.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Low address bits that must be zero for a word access.
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    // Write-back control carried through MEM/WB.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    // A bubble must never write the register file.
    localparam wb_ctrl_t BUBBLE_CTRL = '{reg_write: 1'b0, mem_to_reg: 1'b0};

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits & WORD_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register. Loads every cycle; when bubble is set the
// control bits are forced to the bubble value and the data fields cleared.
module memwb_reg
    import mips_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              bubble,
    input  wb_ctrl_t          ctrl_d,
    input  logic [DATA_W-1:0] read_data_d,
    input  logic [DATA_W-1:0] alu_result_d,
    input  logic [REG_W-1:0]  rd_d,
    output wb_ctrl_t          ctrl_q,
    output logic [DATA_W-1:0] read_data_q,
    output logic [DATA_W-1:0] alu_result_q,
    output logic [REG_W-1:0]  rd_q
);

    // Capture either the incoming result or a bubble on each rising edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctrl_q       <= BUBBLE_CTRL;
            read_data_q  <= '0;
            alu_result_q <= '0;
            rd_q         <= '0;
        end else if (bubble) begin
            ctrl_q       <= BUBBLE_CTRL;
            read_data_q  <= '0;
            alu_result_q <= '0;
            rd_q         <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            rd_q         <= rd_d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline. Issues loads/stores to an
// external data memory, stalls upstream while an access is outstanding,
// aborts on a missing ack after ACK_TIMEOUT cycles, and feeds MEM/WB.
//
// Memory handshake: mem_req/mem_we/mem_addr/mem_wdata are registered and
// stay stable from the cycle mem_req rises until completion. The memory
// answers with a single-cycle mem_ack pulse (mem_rdata valid with it);
// the access completes on the edge that samples mem_ack=1 and mem_req
// falls on that same edge. mem_ack while mem_req=0 is ignored.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [DATA_W-1:0] Address_in,
    input  logic [DATA_W-1:0] WriteData_in,
    input  logic [REG_W-1:0]  Rd_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              Stall,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic [DATA_W-1:0] ReadData_out,
    output logic [DATA_W-1:0] ALU_Result_out,
    output logic [REG_W-1:0]  Rd_out,
    output logic              MisalignErr,
    output logic              BusErr
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_reg_write;
    logic               lat_mem_to_reg;
    logic [REG_W-1:0]   lat_rd;

    logic               acc;
    logic               aligned;
    logic               start;
    logic               misalign;
    logic               ack_done;
    logic               timeout_hit;

    logic               wb_bubble;
    wb_ctrl_t           wb_ctrl_d;
    wb_ctrl_t           wb_ctrl_q;
    logic [DATA_W-1:0]  wb_read_data_d;
    logic [DATA_W-1:0]  wb_alu_result_d;
    logic [REG_W-1:0]   wb_rd_d;

    // A write wins when both MemRead and MemWrite are set (mem_we <= MemWrite_in).
    assign acc      = MemRead_in | MemWrite_in;
    assign aligned  = is_word_aligned(Address_in[1:0]);
    assign start    = (state == S_IDLE) && acc && aligned;
    assign misalign = (state == S_IDLE) && acc && !aligned;
    assign ack_done = (state == S_ACCESS) && mem_ack;

    generate
        if (ACK_TIMEOUT != 0) begin : g_timeout
            assign timeout_hit = (state == S_ACCESS) && !mem_ack &&
                                 (cnt == CNT_W'(ACK_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // Upstream holds during the detect cycle and every un-acked ACCESS cycle;
    // it is released on the ack cycle and on the timeout cycle.
    assign Stall = start || ((state == S_ACCESS) && !mem_ack && !timeout_hit);

    // Access FSM, timeout counter, registered memory request and error pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= S_IDLE;
            cnt            <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            lat_reg_write  <= 1'b0;
            lat_mem_to_reg <= 1'b0;
            lat_rd         <= '0;
            MisalignErr    <= 1'b0;
            BusErr         <= 1'b0;
        end else begin
            MisalignErr <= misalign;
            BusErr      <= timeout_hit;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        state          <= S_ACCESS;
                        mem_req        <= 1'b1;
                        mem_we         <= MemWrite_in;
                        mem_addr       <= Address_in;
                        mem_wdata      <= WriteData_in;
                        lat_reg_write  <= RegWrite_in;
                        lat_mem_to_reg <= MemtoReg_in;
                        lat_rd         <= Rd_in;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack || timeout_hit) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

    // Select what MEM/WB captures: pass-through, completed access, or bubble.
    always_comb begin
        wb_bubble       = 1'b1;
        wb_ctrl_d       = BUBBLE_CTRL;
        wb_read_data_d  = '0;
        wb_alu_result_d = '0;
        wb_rd_d         = '0;
        if ((state == S_IDLE) && !acc) begin
            wb_bubble       = 1'b0;
            wb_ctrl_d       = '{reg_write: RegWrite_in, mem_to_reg: MemtoReg_in};
            wb_alu_result_d = Address_in;
            wb_rd_d         = Rd_in;
        end else if (ack_done) begin
            wb_bubble       = 1'b0;
            wb_ctrl_d       = '{reg_write: lat_reg_write, mem_to_reg: lat_mem_to_reg};
            wb_read_data_d  = mem_we ? '0 : mem_rdata;
            wb_alu_result_d = mem_addr;
            wb_rd_d         = lat_rd;
        end
    end

    memwb_reg u_memwb (
        .CLK          (CLK),
        .RST          (RST),
        .bubble       (wb_bubble),
        .ctrl_d       (wb_ctrl_d),
        .read_data_d  (wb_read_data_d),
        .alu_result_d (wb_alu_result_d),
        .rd_d         (wb_rd_d),
        .ctrl_q       (wb_ctrl_q),
        .read_data_q  (ReadData_out),
        .alu_result_q (ALU_Result_out),
        .rd_q         (Rd_out)
    );

    assign RegWrite_out = wb_ctrl_q.reg_write;
    assign MemtoReg_out = wb_ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a
// randomized instruction stream checked against a transaction-level model.
module tb_mem_access_stage;

    localparam int ACK_TIMEOUT = 16;
    localparam int CNT_W       = 5;
    localparam int REC_W       = 71;  // {RegWrite, MemtoReg, ReadData, ALU_Result, Rd}
    localparam int MAX_CYCLES  = 64;
    localparam int NEVER       = 1000;

    logic        CLK;
    logic        RST;
    logic        RegWrite_in;
    logic        MemtoReg_in;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic [31:0] Address_in;
    logic [31:0] WriteData_in;
    logic [4:0]  Rd_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        Stall;
    logic        RegWrite_out;
    logic        MemtoReg_out;
    logic [31:0] ReadData_out;
    logic [31:0] ALU_Result_out;
    logic [4:0]  Rd_out;
    logic        MisalignErr;
    logic        BusErr;

    mem_access_stage #(.ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .RegWrite_in    (RegWrite_in),
        .MemtoReg_in    (MemtoReg_in),
        .MemRead_in     (MemRead_in),
        .MemWrite_in    (MemWrite_in),
        .Address_in     (Address_in),
        .WriteData_in   (WriteData_in),
        .Rd_in          (Rd_in),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .Stall          (Stall),
        .RegWrite_out   (RegWrite_out),
        .MemtoReg_out   (MemtoReg_out),
        .ReadData_out   (ReadData_out),
        .ALU_Result_out (ALU_Result_out),
        .Rd_out         (Rd_out),
        .MisalignErr    (MisalignErr),
        .BusErr         (BusErr)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int errors = 0;

    // ---------------- scoreboard ----------------
    logic [REC_W-1:0] exp_q[$];

    // Observations gathered by the driver for one instruction.
    logic [REC_W-1:0] obs_last;
    int               obs_cycles;
    int               obs_stall;
    int               obs_access;
    int               obs_mis;
    int               obs_bus;
    int               obs_early_writes;
    logic             obs_unstable;
    logic             obs_req_after;
    logic [31:0]      obs_addr;
    logic             obs_we;
    logic [31:0]      obs_wdata;

    typedef struct {
        logic             bubble;
        logic [REC_W-1:0] rec;
        int               stall;
        int               access;
        int               mis;
        int               bus;
    } exp_t;

    // Transaction-level model: what one instruction should cost and produce.
    function automatic exp_t model(input logic rw, input logic mtr, input logic rd_en,
                                   input logic wr_en, input logic [31:0] addr,
                                   input logic [4:0] rd, input int delay,
                                   input logic [31:0] rdata);
        exp_t e;
        logic is_mem;
        logic misaligned;
        is_mem     = rd_en | wr_en;
        misaligned = (addr % 4) != 0;
        e.bubble = 1'b0;
        e.stall  = 0;
        e.access = 0;
        e.mis    = 0;
        e.bus    = 0;
        e.rec    = {rw, mtr, 32'h0, addr, rd};
        if (is_mem && misaligned) begin
            e.bubble = 1'b1;
            e.mis    = 1;
            e.rec    = '0;
        end else if (is_mem && delay >= ACK_TIMEOUT) begin
            e.bubble = 1'b1;
            e.bus    = 1;
            e.stall  = ACK_TIMEOUT;
            e.access = ACK_TIMEOUT;
            e.rec    = '0;
        end else if (is_mem) begin
            e.stall  = delay + 1;
            e.access = delay + 1;
            e.rec    = {rw, mtr, (wr_en ? 32'h0 : rdata), addr, rd};
        end
        return e;
    endfunction

    // ---------------- driver ----------------
    // Presents one instruction (held while Stall=1) and acts as the memory,
    // acking after 'delay' un-acked request cycles. Called just after a rising edge.
    task automatic issue(input logic rw, input logic mtr, input logic rd_en,
                         input logic wr_en, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input int delay, input logic [31:0] rdata);
        logic stall_now;
        logic prev_rw;
        bit   done;
        RegWrite_in      = rw;
        MemtoReg_in      = mtr;
        MemRead_in       = rd_en;
        MemWrite_in      = wr_en;
        Address_in       = addr;
        WriteData_in     = wdata;
        Rd_in            = rd;
        mem_ack          = 1'b0;
        obs_cycles       = 0;
        obs_stall        = 0;
        obs_access       = 0;
        obs_mis          = 0;
        obs_bus          = 0;
        obs_early_writes = 0;
        obs_unstable     = 1'b0;
        obs_addr         = '0;
        obs_we           = 1'b0;
        obs_wdata        = '0;
        prev_rw          = 1'b0;
        done             = 1'b0;
        while (!done && obs_cycles < MAX_CYCLES) begin
            if (mem_req) begin
                if (obs_access == 0) begin
                    obs_addr  = mem_addr;
                    obs_we    = mem_we;
                    obs_wdata = mem_wdata;
                end else if (mem_addr !== obs_addr || mem_we !== obs_we ||
                             mem_wdata !== obs_wdata) begin
                    obs_unstable = 1'b1;
                end
                if (obs_access == delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                obs_access++;
            end
            @(negedge CLK);
            stall_now = Stall;
            if (stall_now) obs_stall++;
            @(posedge CLK);
            #1;
            mem_ack = 1'b0;
            if (obs_cycles > 0 && prev_rw) obs_early_writes++;
            prev_rw  = RegWrite_out;
            obs_last = {RegWrite_out, MemtoReg_out, ReadData_out, ALU_Result_out, Rd_out};
            if (MisalignErr) obs_mis++;
            if (BusErr) obs_bus++;
            obs_cycles++;
            done = !stall_now;
        end
        obs_req_after = mem_req;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL stall_budget: still stalled after %0d cycles, want release", obs_cycles);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        RST          = 1'b1;
        RegWrite_in  = 1'b0;
        MemtoReg_in  = 1'b0;
        MemRead_in   = 1'b0;
        MemWrite_in  = 1'b0;
        Address_in   = '0;
        WriteData_in = '0;
        Rd_in        = '0;
        mem_rdata    = '0;
        mem_ack      = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, Stall, RegWrite_out, MemtoReg_out,
             ReadData_out, ALU_Result_out, Rd_out, MisalignErr, BusErr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h stall=%b rw=%b mtr=%b rdat=%h alu=%h rd=%h mis=%b bus=%b, want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, Stall, RegWrite_out, MemtoReg_out,
                     ReadData_out, ALU_Result_out, Rd_out, MisalignErr, BusErr);
        end
        RST = 1'b0;
    endtask

    task automatic test_alu_op;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_00A4, 32'h0, 5'd5, 0, 32'h0);
        checks++;
        if (obs_stall !== 0) begin
            errors++;
            $display("FAIL alu_stall: got %0d stall cycles, want 0", obs_stall);
        end
        checks++;
        if (obs_last !== {1'b1, 1'b0, 32'h0, 32'h0000_00A4, 5'd5}) begin
            errors++;
            $display("FAIL alu_result: got %h, want %h", obs_last,
                     {1'b1, 1'b0, 32'h0, 32'h0000_00A4, 5'd5});
        end
    endtask

    task automatic test_load;
        issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd8, 3, 32'hDEAD_BEEF);
        checks++;
        if (obs_stall !== 4) begin
            errors++;
            $display("FAIL load_stall: got %0d, want 4", obs_stall);
        end
        checks++;
        if (obs_access !== 4 || obs_addr !== 32'h100 || obs_we !== 1'b0 || obs_unstable) begin
            errors++;
            $display("FAIL load_request: access=%0d addr=%h we=%b unstable=%b, want 4 100 0 0",
                     obs_access, obs_addr, obs_we, obs_unstable);
        end
        checks++;
        if (obs_early_writes !== 0 || obs_cycles !== 5) begin
            errors++;
            $display("FAIL load_bubbles: early_writes=%0d cycles=%0d, want 0 and 5",
                     obs_early_writes, obs_cycles);
        end
        checks++;
        if (obs_last !== {1'b1, 1'b1, 32'hDEAD_BEEF, 32'h100, 5'd8}) begin
            errors++;
            $display("FAIL load_result: got %h, want %h", obs_last,
                     {1'b1, 1'b1, 32'hDEAD_BEEF, 32'h100, 5'd8});
        end
        checks++;
        if (obs_req_after !== 1'b0) begin
            errors++;
            $display("FAIL load_req_drop: got %b, want 0", obs_req_after);
        end
    endtask

    task automatic test_store;
        issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 5'd7, 0, 32'hAAAA_5555);
        checks++;
        if (obs_stall !== 1) begin
            errors++;
            $display("FAIL store_stall: got %0d, want 1", obs_stall);
        end
        checks++;
        if (obs_we !== 1'b1 || obs_wdata !== 32'h1234_5678 || obs_addr !== 32'h200) begin
            errors++;
            $display("FAIL store_request: we=%b wdata=%h addr=%h, want 1 12345678 200",
                     obs_we, obs_wdata, obs_addr);
        end
        checks++;
        if (obs_last !== {1'b0, 1'b0, 32'h0, 32'h200, 5'd7}) begin
            errors++;
            $display("FAIL store_result: got %h, want %h", obs_last,
                     {1'b0, 1'b0, 32'h0, 32'h200, 5'd7});
        end
    endtask

    task automatic test_misalign;
        issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd4, 0, 32'h0);
        checks++;
        if (obs_stall !== 0 || obs_access !== 0) begin
            errors++;
            $display("FAIL misalign_no_req: stall=%0d access=%0d, want 0 0", obs_stall, obs_access);
        end
        checks++;
        if (obs_mis !== 1) begin
            errors++;
            $display("FAIL misalign_pulse: got %0d, want 1", obs_mis);
        end
        checks++;
        if (obs_last[REC_W-1 -: 2] !== 2'b00) begin
            errors++;
            $display("FAIL misalign_bubble: ctrl=%b, want 00", obs_last[REC_W-1 -: 2]);
        end
    endtask

    task automatic test_timeout;
        issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd10, NEVER, 32'h0);
        checks++;
        if (obs_stall !== 16 || obs_access !== 16) begin
            errors++;
            $display("FAIL timeout_length: stall=%0d access=%0d, want 16 16", obs_stall, obs_access);
        end
        checks++;
        if (obs_bus !== 1 || obs_req_after !== 1'b0) begin
            errors++;
            $display("FAIL timeout_buserr: bus=%0d req_after=%b, want 1 0", obs_bus, obs_req_after);
        end
        checks++;
        if (obs_last[REC_W-1 -: 2] !== 2'b00 || obs_early_writes !== 0) begin
            errors++;
            $display("FAIL timeout_bubble: ctrl=%b early_writes=%0d, want 00 0",
                     obs_last[REC_W-1 -: 2], obs_early_writes);
        end
    endtask

    task automatic test_stray_ack;
        RegWrite_in = 1'b1;
        MemtoReg_in = 1'b0;
        MemRead_in  = 1'b0;
        MemWrite_in = 1'b0;
        Address_in  = 32'h0000_007C;
        Rd_in       = 5'd12;
        mem_rdata   = 32'hFFFF_FFFF;
        mem_ack     = 1'b1;
        @(negedge CLK);
        checks++;
        if (Stall !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack_stall: got %b, want 0", Stall);
        end
        @(posedge CLK);
        #1;
        mem_ack = 1'b0;
        checks++;
        if ({mem_req, RegWrite_out, MemtoReg_out, ReadData_out, ALU_Result_out, Rd_out} !==
            {1'b0, 1'b1, 1'b0, 32'h0, 32'h7C, 5'd12}) begin
            errors++;
            $display("FAIL stray_ack_pass: req=%b rw=%b mtr=%b rdat=%h alu=%h rd=%0d, want 0 1 0 0 7c 12",
                     mem_req, RegWrite_out, MemtoReg_out, ReadData_out, ALU_Result_out, Rd_out);
        end
    endtask

    task automatic test_reset_mid_access;
        RegWrite_in = 1'b1;
        MemtoReg_in = 1'b1;
        MemRead_in  = 1'b1;
        MemWrite_in = 1'b0;
        Address_in  = 32'h0000_0400;
        Rd_in       = 5'd9;
        mem_ack     = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_req_up: got %b, want 1", mem_req);
        end
        @(posedge CLK);
        #1;
        RST         = 1'b1;
        MemRead_in  = 1'b0;
        RegWrite_in = 1'b0;
        MemtoReg_in = 1'b0;
        Address_in  = '0;
        Rd_in       = '0;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, Stall, RegWrite_out, MemtoReg_out,
             ReadData_out, ALU_Result_out, Rd_out, MisalignErr, BusErr} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: req=%b stall=%b rw=%b alu=%h, want all 0",
                     mem_req, Stall, RegWrite_out, ALU_Result_out);
        end
        #1;
        RST         = 1'b0;
        RegWrite_in = 1'b1;
        Address_in  = 32'h0000_005C;
        Rd_in       = 5'd3;
        mem_rdata   = 32'h5555_AAAA;
        mem_ack     = 1'b1;
        @(negedge CLK);
        checks++;
        if (Stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_late_ack_stall: got %b, want 0", Stall);
        end
        @(posedge CLK);
        #1;
        mem_ack = 1'b0;
        checks++;
        if ({mem_req, RegWrite_out, MemtoReg_out, ReadData_out, ALU_Result_out, Rd_out} !==
            {1'b0, 1'b1, 1'b0, 32'h0, 32'h5C, 5'd3}) begin
            errors++;
            $display("FAIL rst_next_alu: req=%b rw=%b mtr=%b rdat=%h alu=%h rd=%0d, want 0 1 0 0 5c 3",
                     mem_req, RegWrite_out, MemtoReg_out, ReadData_out, ALU_Result_out, Rd_out);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            logic        rw;
            logic        mtr;
            logic        rd_en;
            logic        wr_en;
            logic [31:0] addr;
            logic [31:0] wdata;
            logic [31:0] rdata;
            logic [4:0]  rd;
            int          kind;
            int          delay;
            exp_t        e;
            logic [REC_W-1:0] want;
            kind  = $urandom_range(0, 4);
            rw    = 1'($urandom);
            mtr   = 1'($urandom);
            rd    = 5'($urandom);
            wdata = $urandom;
            rdata = $urandom;
            addr  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            rd_en = (kind == 1) || (kind == 3) || (kind == 4);
            wr_en = (kind == 2) || (kind == 3);
            if (kind == 4) addr[1:0] = 2'($urandom_range(1, 3));
            delay = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 6);
            e = model(rw, mtr, rd_en, wr_en, addr, rd, delay, rdata);
            exp_q.push_back(e.rec);
            issue(rw, mtr, rd_en, wr_en, addr, wdata, rd, delay, rdata);
            want = exp_q.pop_front();
            checks++;
            if (e.bubble ? (obs_last[REC_W-1 -: 2] !== 2'b00) : (obs_last !== want)) begin
                errors++;
                $display("FAIL rand_result[%0d]: got %h, want %h (bubble=%b)", n, obs_last, want, e.bubble);
            end
            checks++;
            if (obs_stall !== e.stall || obs_access !== e.access || obs_early_writes !== 0) begin
                errors++;
                $display("FAIL rand_timing[%0d]: stall=%0d access=%0d early=%0d, want %0d %0d 0",
                         n, obs_stall, obs_access, obs_early_writes, e.stall, e.access);
            end
            checks++;
            if (obs_mis !== e.mis || obs_bus !== e.bus || obs_req_after !== 1'b0) begin
                errors++;
                $display("FAIL rand_flags[%0d]: mis=%0d bus=%0d req_after=%b, want %0d %0d 0",
                         n, obs_mis, obs_bus, obs_req_after, e.mis, e.bus);
            end
            if (e.access > 0) begin
                checks++;
                if (obs_addr !== addr || obs_we !== wr_en || obs_unstable ||
                    (wr_en && obs_wdata !== wdata)) begin
                    errors++;
                    $display("FAIL rand_request[%0d]: addr=%h we=%b wdata=%h unstable=%b, want %h %b %h 0",
                             n, obs_addr, obs_we, obs_wdata, obs_unstable, addr, wr_en, wdata);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_misalign();
        test_timeout();
        test_stray_ack();
        test_random();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
